// File: rtl/multicycle_control_fsm_if.sv
// Control bus between the multicycle controller and its datapath.
// The controller side (master) receives the instruction, the ALU zero flag
// and the memory handshake. It drives every datapath enable and mux select,
// plus the sticky illegal flag and the debug state code.
interface multicycle_control_fsm_if;

  // Inputs to the controller
  logic        zero;
  logic [31:0] Instr;
  logic        mem_ready;

  // Datapath enables and strobes
  logic        PCWrite;
  logic        AdrSrc;
  logic        MemWrite;
  logic        IRWrite;
  logic        RegWrite;

  // Mux selects and ALU/immediate decode
  logic [1:0]  ResultSrc;
  logic [1:0]  ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  ImmSrc;
  logic [2:0]  ALUControl;

  // Status
  logic        illegal;
  logic [3:0]  state;

  modport master (
    input  zero,
    input  Instr,
    input  mem_ready,
    output PCWrite,
    output AdrSrc,
    output MemWrite,
    output IRWrite,
    output RegWrite,
    output ResultSrc,
    output ALUSrcA,
    output ALUSrcB,
    output ImmSrc,
    output ALUControl,
    output illegal,
    output state
  );

  modport slave (
    output zero,
    output Instr,
    output mem_ready,
    input  PCWrite,
    input  AdrSrc,
    input  MemWrite,
    input  IRWrite,
    input  RegWrite,
    input  ResultSrc,
    input  ALUSrcA,
    input  ALUSrcB,
    input  ImmSrc,
    input  ALUControl,
    input  illegal,
    input  state
  );

endinterface

// File: rtl/multicycle_control_fsm.sv
// Main controller for a multicycle RISC-V subset (lw, sw, R-type, I-type
// ALU, jal, beq). Moore FSM with registered state. Only a few outputs are not
// pure functions of the state:
//   - IRWrite and PCWrite in FETCH follow mem_ready.
//   - PCWrite in BEQ follows zero.
//   - ALUControl and ImmSrc are also decoded from the instruction.
// Any unsupported opcode parks the machine in TRAP with a sticky illegal
// flag. Only reset leaves TRAP.
module multicycle_control_fsm (
  input logic                       clk,
  input logic                       rst_n,
  multicycle_control_fsm_if.master  bus
);

  // State codes are visible on the debug port, so they are fixed values
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_ALUWB    = 4'd7;
  localparam logic [3:0] S_EXECI    = 4'd8;
  localparam logic [3:0] S_JAL      = 4'd9;
  localparam logic [3:0] S_BEQ      = 4'd10;
  localparam logic [3:0] S_TRAP     = 4'd11;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic       illegal_q;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_b5;
  logic       op_b5;

  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] imm_src;
  logic [2:0] alu_control;

  // Only the opcode, funct3 and the sub/sra distinguishing bits matter here
  logic       unused_instr_bits;

  assign opcode            = bus.Instr[6:0];
  assign funct3            = bus.Instr[14:12];
  assign funct7_b5         = bus.Instr[30];
  assign op_b5             = bus.Instr[5];
  assign unused_instr_bits = ^{bus.Instr[31], bus.Instr[29:15], bus.Instr[11:7]};

  // State register and sticky illegal flag; reset abandons any instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d == S_TRAP) begin
        illegal_q <= 1'b1;
      end
    end
  end

  // Next-state selection; unused codes fall back to FETCH
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW,
          OP_SW:    state_d = S_MEMADR;
          OP_RTYPE: state_d = S_EXECR;
          OP_ITYPE: state_d = S_EXECI;
          OP_JAL:   state_d = S_JAL;
          OP_BEQ:   state_d = S_BEQ;
          default:  state_d = S_TRAP;
        endcase
      end
      S_MEMADR:   state_d = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = bus.mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = bus.mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_BEQ:      state_d = S_FETCH;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_FETCH;
    endcase
  end

  // Per-state datapath controls; anything not set stays inactive
  always_comb begin
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = bus.mem_ready;
        pc_write   = bus.mem_ready;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = ALUOP_FUNCT;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
      end
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = ALUOP_SUB;
        pc_write  = bus.zero;
      end
      default: begin
      end
    endcase
  end

  // ALU operation: add/sub directly, or the funct3/funct7 decode for ALU ops
  always_comb begin
    alu_control = 3'b000;
    case (alu_op)
      ALUOP_SUB:   alu_control = 3'b001;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alu_control = (op_b5 && funct7_b5) ? 3'b001 : 3'b000;
          3'b010:  alu_control = 3'b101;
          3'b110:  alu_control = 3'b011;
          3'b111:  alu_control = 3'b010;
          default: alu_control = 3'b000;
        endcase
      end
      default:     alu_control = 3'b000;
    endcase
  end

  // Immediate format follows the opcode regardless of state
  always_comb begin
    imm_src = 2'b00;
    case (opcode)
      OP_SW:   imm_src = 2'b01;
      OP_BEQ:  imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

  assign bus.PCWrite    = pc_write;
  assign bus.AdrSrc     = adr_src;
  assign bus.MemWrite   = mem_write;
  assign bus.IRWrite    = ir_write;
  assign bus.RegWrite   = reg_write;
  assign bus.ResultSrc  = result_src;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ImmSrc     = imm_src;
  assign bus.ALUControl = alu_control;
  assign bus.illegal    = illegal_q;
  assign bus.state      = state_q;

endmodule
